// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: turns hazard indications from the five pipeline
// stages into PC / pipeline-register enables and bubble inserts, keeps a sticky
// halt flag and saturating stall/flush statistics counters.
module hazard_ctrl (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        memREN,
    input  logic        memWEN,
    input  logic        exDRE,
    input  logic [4:0]  exrt,
    input  logic [4:0]  idrs,
    input  logic [4:0]  idrt,
    input  logic        brTaken,
    input  logic        jmpID,
    input  logic        wbHALT,
    output logic        pcEN,
    output logic        ifidW,
    output logic        idexW,
    output logic        exmemW,
    output logic        memwbW,
    output logic        ifidRST,
    output logic        idexRST,
    output logic        exmemRST,
    output logic        memwbRST,
    output logic        halt,
    output logic [31:0] stallCnt,
    output logic [15:0] flushCnt
);

    typedef enum logic [1:0] {StInit, StRun, StHalted} state_e;

    state_e      state_q, state_d;
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;
    logic        stall_inc, flush_inc;
    logic        dmem_wait, load_use;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign dmem_wait = (memREN | memWEN) & ~dhit;
    assign load_use  = exDRE & (exrt != 5'd0) & ((exrt == idrs) | (exrt == idrt));

    assign stallCnt = stall_cnt_q;
    assign flushCnt = flush_cnt_q;

    // State register: asynchronous reset back to INIT.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    // Saturating statistics counters; they only advance while running.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_inc && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    // Next state and prioritised hazard response; the first matching condition wins.
    always_comb begin
        state_d   = state_q;
        pcEN      = 1'b0;
        ifidW     = 1'b0;
        idexW     = 1'b0;
        exmemW    = 1'b0;
        memwbW    = 1'b0;
        ifidRST   = 1'b0;
        idexRST   = 1'b0;
        exmemRST  = 1'b0;
        memwbRST  = 1'b0;
        halt      = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        unique case (state_q)
            StInit: begin
                ifidRST  = 1'b1;
                idexRST  = 1'b1;
                exmemRST = 1'b1;
                memwbRST = 1'b1;
                state_d  = StRun;
            end
            StRun: begin
                if (wbHALT) begin
                    halt    = 1'b1;
                    state_d = StHalted;
                end else if (dmem_wait) begin
                    // Freeze everything upstream; bubble leaves MEM toward WB.
                    memwbRST  = 1'b1;
                    stall_inc = 1'b1;
                end else if (brTaken) begin
                    pcEN      = 1'b1;
                    ifidRST   = 1'b1;
                    idexRST   = 1'b1;
                    exmemRST  = 1'b1;
                    memwbW    = 1'b1;
                    flush_inc = 1'b1;
                end else if (load_use) begin
                    idexRST   = 1'b1;
                    exmemW    = 1'b1;
                    memwbW    = 1'b1;
                    stall_inc = 1'b1;
                end else if (jmpID) begin
                    pcEN      = ihit;
                    ifidRST   = 1'b1;
                    idexW     = 1'b1;
                    exmemW    = 1'b1;
                    memwbW    = 1'b1;
                    flush_inc = 1'b1;
                end else if (!ihit) begin
                    ifidRST   = 1'b1;
                    idexW     = 1'b1;
                    exmemW    = 1'b1;
                    memwbW    = 1'b1;
                    stall_inc = 1'b1;
                end else begin
                    pcEN   = 1'b1;
                    ifidW  = 1'b1;
                    idexW  = 1'b1;
                    exmemW = 1'b1;
                    memwbW = 1'b1;
                end
            end
            StHalted: begin
                halt = 1'b1;
            end
            default: begin
                ifidRST  = 1'b1;
                idexRST  = 1'b1;
                exmemRST = 1'b1;
                memwbRST = 1'b1;
                state_d  = StInit;
            end
        endcase
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a per-cycle reference model classifies each cycle by
// the hazard rules and compares every output, plus directed literal checks.
module tb_hazard_ctrl;

    logic        CLK, nRST;
    logic        ihit, dhit, memREN, memWEN, exDRE, brTaken, jmpID, wbHALT;
    logic [4:0]  exrt, idrs, idrt;
    logic        pcEN, ifidW, idexW, exmemW, memwbW;
    logic        ifidRST, idexRST, exmemRST, memwbRST, halt;
    logic [31:0] stallCnt;
    logic [15:0] flushCnt;

    int total = 0;
    int bad   = 0;

    hazard_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .memREN(memREN),
        .memWEN(memWEN), .exDRE(exDRE), .exrt(exrt), .idrs(idrs), .idrt(idrt),
        .brTaken(brTaken), .jmpID(jmpID), .wbHALT(wbHALT), .pcEN(pcEN),
        .ifidW(ifidW), .idexW(idexW), .exmemW(exmemW), .memwbW(memwbW),
        .ifidRST(ifidRST), .idexRST(idexRST), .exmemRST(exmemRST),
        .memwbRST(memwbRST), .halt(halt), .stallCnt(stallCnt), .flushCnt(flushCnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {pcEN, ifidW, idexW, exmemW, memwbW, ifidRST, idexRST, exmemRST, memwbRST, halt}
    logic [9:0] outs;
    assign outs = {pcEN, ifidW, idexW, exmemW, memwbW,
                   ifidRST, idexRST, exmemRST, memwbRST, halt};

    localparam logic [9:0] VInit  = 10'b0_0000_1111_0;
    localparam logic [9:0] VHalt  = 10'b0_0000_0000_1;
    localparam logic [9:0] VDwait = 10'b0_0000_0001_0;
    localparam logic [9:0] VBr    = 10'b1_0001_1110_0;
    localparam logic [9:0] VLu    = 10'b0_0011_0100_0;
    localparam logic [9:0] VImiss = 10'b0_0111_1000_0;
    localparam logic [9:0] VNorm  = 10'b1_1111_0000_0;

    localparam int CInit = 0, CHalt = 1, CDwait = 2, CBr = 3;
    localparam int CLu = 4, CJmp = 5, CImiss = 6, CNorm = 7;

    // Model: mode 0 = first cycle after reset, 1 = running, 2 = halted.
    int      m_mode = 0;
    longint  m_stall = 0;
    longint  m_flush = 0;
    int      m_cat;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int classify(input int mode);
        if (mode == 0) return CInit;
        if (mode == 2) return CHalt;
        if (wbHALT) return CHalt;
        if ((memREN || memWEN) && !dhit) return CDwait;
        if (brTaken) return CBr;
        if (exDRE && exrt != 0 && (exrt == idrs || exrt == idrt)) return CLu;
        if (jmpID) return CJmp;
        if (!ihit) return CImiss;
        return CNorm;
    endfunction

    function automatic logic [9:0] expected(input int c);
        case (c)
            CInit:   return VInit;
            CHalt:   return VHalt;
            CDwait:  return VDwait;
            CBr:     return VBr;
            CLu:     return VLu;
            CJmp:    return {ihit, 9'b0111_1000_0};
            CImiss:  return VImiss;
            default: return VNorm;
        endcase
    endfunction

    // Model advance on each clock edge, async reset like the DUT.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_mode  <= 0;
            m_stall <= 0;
            m_flush <= 0;
        end else begin
            m_cat = classify(m_mode);
            if (m_mode == 0) m_mode <= 1;
            else if (m_mode == 1 && m_cat == CHalt) m_mode <= 2;
            if (m_cat == CDwait || m_cat == CLu || m_cat == CImiss) m_stall <= m_stall + 1;
            if (m_cat == CBr || m_cat == CJmp) m_flush <= m_flush + 1;
        end
    end

    // Per-cycle compare on the falling edge, away from the active edge.
    always @(negedge CLK) begin
        chk("cyc_outs", {54'd0, outs}, {54'd0, expected(classify(m_mode))});
        chk("cyc_stall", {32'd0, stallCnt},
            (m_stall > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_stall);
        chk("cyc_flush", {48'd0, flushCnt}, (m_flush > 65535) ? 64'd65535 : m_flush);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b1; memREN = 1'b0; memWEN = 1'b0; exDRE = 1'b0;
        brTaken = 1'b0; jmpID = 1'b0; wbHALT = 1'b0;
        exrt = 5'd0; idrs = 5'd0; idrt = 5'd0;
    endtask

    task automatic rand_hazards();
        ihit    = ($urandom_range(0, 7) != 0);
        dhit    = ($urandom_range(0, 3) != 0);
        memREN  = ($urandom_range(0, 5) == 0);
        memWEN  = ($urandom_range(0, 5) == 0);
        exDRE   = $urandom_range(0, 1) == 1;
        exrt    = 5'($urandom_range(0, 3));
        idrs    = 5'($urandom_range(0, 3));
        idrt    = 5'($urandom_range(0, 3));
        brTaken = ($urandom_range(0, 7) == 0);
        jmpID   = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        nRST = 1'b1;
        idle();
        #1 nRST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_pcEN", {63'd0, pcEN}, 64'd0);
        chk("rst_regs", {54'd0, outs}, {54'd0, VInit});

        // Reset release: one INIT cycle, then normal flow.
        nRST = 1'b1;
        #3 chk("init_cycle", {54'd0, outs}, {54'd0, VInit});
        step();
        #3 chk("run_normal", {54'd0, outs}, {54'd0, VNorm});
        chk("run_stall0", {32'd0, stallCnt}, 64'd0);

        // Load-use on rt.
        step(); exDRE = 1'b1; exrt = 5'd5; idrt = 5'd5; idrs = 5'd3;
        #3 chk("lu_outs", {54'd0, outs}, {54'd0, VLu});
        chk("lu_stall_before", {32'd0, stallCnt}, 64'd0);
        step(); idle();
        #3 chk("lu_stall_after", {32'd0, stallCnt}, 64'd1);

        // Load to r0 never stalls.
        step(); exDRE = 1'b1; exrt = 5'd0; idrs = 5'd0; idrt = 5'd0;
        #3 chk("lu_r0_outs", {54'd0, outs}, {54'd0, VNorm});
        step(); idle();
        #3 chk("lu_r0_stall", {32'd0, stallCnt}, 64'd1);

        // Three-cycle data memory wait.
        for (int i = 0; i < 3; i++) begin
            step(); memREN = 1'b1; dhit = 1'b0;
            #3 chk("dwait_outs", {54'd0, outs}, {54'd0, VDwait});
        end
        step(); dhit = 1'b1;
        #3 chk("dwait_done", {54'd0, outs}, {54'd0, VNorm});
        step(); idle();
        #3 chk("dwait_stall", {32'd0, stallCnt}, 64'd4);

        // Branch beats load-use and icache miss.
        step(); brTaken = 1'b1; exDRE = 1'b1; exrt = 5'd7; idrs = 5'd7; ihit = 1'b0;
        #3 chk("br_outs", {54'd0, outs}, {54'd0, VBr});
        step(); idle();
        #3 chk("br_flush", {48'd0, flushCnt}, 64'd1);
        chk("br_stall", {32'd0, stallCnt}, 64'd4);

        // Randomized traffic with occasional halts and reset pulses.
        for (int i = 0; i < 3000; i++) begin
            step();
            rand_hazards();
            wbHALT = ($urandom_range(0, 299) == 0);
            nRST   = ($urandom_range(0, 149) != 0);
        end

        // Halt dominates hazards and is sticky until reset.
        step(); idle(); nRST = 1'b0;
        step(); nRST = 1'b1;
        step();
        wbHALT = 1'b1; memREN = 1'b1; dhit = 1'b0; brTaken = 1'b1;
        #3 chk("halt_now", {54'd0, outs}, {54'd0, VHalt});
        step(); wbHALT = 1'b0;
        #3 chk("halt_sticky", {54'd0, outs}, {54'd0, VHalt});
        for (int i = 0; i < 5; i++) begin
            step(); rand_hazards();
        end
        #3 chk("halt_later", {63'd0, halt}, 64'd1);
        chk("halt_frozen", {32'd0, stallCnt, flushCnt}, 64'd0);
        step(); nRST = 1'b0;
        #3 chk("halt_cleared", {54'd0, outs}, {54'd0, VInit});
        step(); idle(); nRST = 1'b1;
        step();

        // Flush counter saturation.
        brTaken = 1'b1;
        repeat (65540) step();
        idle();
        #3 chk("flush_sat", {48'd0, flushCnt}, 64'h0000_FFFF);
        chk("flush_sat_stall", {32'd0, stallCnt}, 64'd0);
        step();
        #3;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 CLK  in  1  clock; all state updates on rising edge.
REQ-002 nRST  in  1  reset, asynchronous, active-low.
REQ-003 ihit  in  1  instruction memory returned valid instruction this cycle.
REQ-004 dhit  in  1  data memory access in MEM completed this cycle.
REQ-005 memREN, memWEN  in  1 each  MEM-stage instruction is a load / store.
REQ-006 exDRE  in  1  EX-stage instruction is a load.
REQ-007 exrt  in  5  EX-stage destination register of the load.
REQ-008 idrs, idrt  in  5 each  ID-stage source registers.
REQ-009 brTaken  in  1  branch resolved taken in MEM.
REQ-010 jmpID  in  1  ID-stage instruction is J/JAL/JR.
REQ-011 wbHALT  in  1  halt instruction in WB.
REQ-012 pcEN  out  1  PC update enable.
REQ-013 ifidW, idexW, exmemW, memwbW  out  1 each  latch enable per pipeline register.
REQ-014 ifidRST, idexRST, exmemRST, memwbRST  out  1 each  synchronous bubble insert per pipeline register (overrides W in that register).
REQ-015 halt  out  1  sticky CPU halted flag.
REQ-016 stallCnt  out  32  saturating stall-cycle count.
REQ-017 flushCnt  out  16  saturating flush-event count.

Function
REQ-018 States: INIT, RUN, HALTED; state register, stallCnt, flushCnt are the only storage.
REQ-019 INIT: pcEN=0, all W=0, all RST=1, halt=0; next state RUN unconditionally.
REQ-020 HALTED: pcEN=0, all W=0, all RST=0, halt=1; remains HALTED until nRST; counters frozen.
REQ-021 RUN, no condition active: pcEN=1, all W=1, all RST=0.
REQ-022 RUN conditions evaluated in priority order; first match alone sets outputs.
REQ-023 P1 wbHALT=1: outputs as HALTED for this cycle; next state HALTED.
REQ-024 P2 dmem wait, (memREN|memWEN)&!dhit: pcEN=0, ifidW=idexW=exmemW=0, memwbRST=1, other RST=0.
REQ-025 P3 brTaken=1: ifidRST=idexRST=exmemRST=1, memwbW=1, pcEN=1; flushCnt+1.
REQ-026 P4 load-use, exDRE & exrt!=0 & (exrt==idrs | exrt==idrt): pcEN=0, ifidW=0, idexRST=1, exmemW=memwbW=1.
REQ-027 P5 jmpID=1: ifidRST=1, idexW=exmemW=memwbW=1, pcEN=ihit; flushCnt+1.
REQ-028 P6 ihit=0: pcEN=0, ifidRST=1, idexW=exmemW=memwbW=1.
REQ-029 stallCnt +1 in each RUN cycle where P2, P4 or P6 selected; no change otherwise.
REQ-030 Both counters saturate at all-ones, never wrap.
REQ-031 Outputs combinational from current state and inputs; zero latency to hazard response.
REQ-032 exrt==0 never triggers load-use stall; simultaneous brTaken and load-use resolves as P3 (flush wins).
REQ-033 For any register, RST=1 implies W ignored; W and RST never both 1 in the same cycle for one register.

Reset
REQ-034 nRST=0 asynchronously forces state INIT, stallCnt=0, flushCnt=0, halt=0.
REQ-035 While nRST=0: pcEN=0, all W=0, all RST=1.
REQ-036 nRST asserted mid-stall or in HALTED returns to INIT immediately; first post-reset cycle is INIT, then RUN.

Verification
REQ-037 Release reset, ihit=1, no hazards -> cycle1 INIT (all RST=1), cycle2 onward pcEN=1, all W=1, stallCnt=0.
REQ-038 RUN, exDRE=1, exrt=5, idrt=5 for one cycle -> pcEN=0, ifidW=0, idexRST=1, stallCnt 0->1; exrt=0, idrs=0 -> no stall.
REQ-039 memREN=1, dhit=0 for 3 cycles then dhit=1 -> 3 cycles memwbRST=1, upstream frozen, stallCnt+=3; 4th cycle normal.
REQ-040 brTaken=1 with load-use and ihit=0 same cycle -> ifid/idex/exmemRST=1, pcEN=1, flushCnt+1, stallCnt unchanged.
REQ-041 wbHALT=1 -> halt=1 next and every later cycle, pcEN=0, all W=0 despite hazard inputs; nRST pulse clears halt.
REQ-042 Preload stallCnt via 2^32+2 stall cycles (or forced state) -> holds 0xFFFFFFFF, no wrap.
